rf_stream_reader: RTL and testbench

RF_STREAM_READER -- requirements
Module: rf_stream_reader

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_stream_reader.sv | 146 ++++++++++++++
 tb/tb_rf_stream_reader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file constants and burst-reader FSM states
//
// Purpose: constants shared by register_file users and the burst reader,
//          plus the reader's FSM state encoding.
// Ports:   none (package).

package rf_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 4;
    localparam int RF_DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FINISH = 2'd2
    } rf_state_e;

endpackage

// File: rtl/rf_stream_reader.sv
// rtl/rf_stream_reader.sv - burst reader streaming register-file words with a running checksum
//
// Purpose: on start, reads count words (clamped to the file depth) from a
//          combinational register file beginning at base, wrapping at the top,
//          and streams them out with valid/ready handshaking and a checksum.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, base, count  burst request, sampled only in IDLE
//   abort             cancel the burst in progress
//   rf_addr, rf_data  register-file read address / combinational read data
//   out_valid, out_ready, out_data  output word stream
//   busy              not IDLE
//   done              one-cycle completion pulse
//   checksum          modulo-2**DATA_W sum of transferred words, valid with done

module rf_stream_reader #(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    import rf_pkg::rf_state_e;
    import rf_pkg::ST_IDLE;
    import rf_pkg::ST_STREAM;
    import rf_pkg::ST_FINISH;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    rf_state_e         state;
    rf_state_e         state_next;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   index;      // words issued so far in this burst
    logic [ADDR_W:0]   eff_count;
    logic              xfer;
    logic              all_issued;
    logic              issue;
    logic              last_xfer;

    assign eff_count  = (count > DEPTH) ? DEPTH : count;
    assign xfer       = out_valid && out_ready;
    assign all_issued = (index == cnt_q);
    // A new word may be issued when the output register is empty or is being
    // drained this same cycle, which gives back-to-back words.
    assign issue      = (state == ST_STREAM) && !abort && !all_issued &&
                        (!out_valid || out_ready);
    // With at most one word in flight, a transfer after the final issue is the last.
    assign last_xfer  = xfer && all_issued;

    // Address follows the issue index, so it holds while the output is stalled
    // and keeps its last value in IDLE.
    assign rf_addr = base_q + index[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (eff_count == '0) ? ST_FINISH : ST_STREAM;
                end
            end
            ST_STREAM: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (last_xfer) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                busy       = 1'b1;
                done       = !abort;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q    <= '0;
            cnt_q     <= '0;
            index     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            checksum  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q   <= base;
                        cnt_q    <= eff_count;
                        index    <= '0;
                        checksum <= '0;
                    end
                end
                ST_STREAM: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                    end else begin
                        if (xfer) begin
                            checksum <= checksum + out_data;
                        end
                        if (issue) begin
                            out_data  <= rf_data;
                            out_valid <= 1'b1;
                            index     <= index + (ADDR_W+1)'(1);
                        end else if (xfer) begin
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_stream_reader.sv
// tb/tb_rf_stream_reader.sv - self-checking bench for rf_stream_reader with a register-file model

module tb_rf_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] base;
    logic [4:0] count;
    logic       abort;
    logic [3:0] rf_addr;
    logic [7:0] rf_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic       done;
    logic [7:0] checksum;

    logic [7:0] rf_mem [16];

    always #5 clk = ~clk;

    assign rf_data = rf_mem[rf_addr];

    rf_stream_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base      (base),
        .count     (count),
        .abort     (abort),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] got_q [$];
    logic [7:0] got_sum;
    int         first_v;
    int         done_cyc;
    int         last_x;
    int         gaps;
    int         stall_seen;

    typedef struct {
        int         b;
        int         c;
        int         mode;
        logic [7:0] exp_sum;
        int         exp_n;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic int eff_len(input int c);
        return (c > 16) ? 16 : c;
    endfunction

    function automatic logic [7:0] model_word(input int b, input int i);
        return rf_mem[(b + i) % 16];
    endfunction

    function automatic logic [7:0] model_sum(input int b, input int c);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < eff_len(c); i++) s = s + model_word(b, i);
        return s;
    endfunction

    // mode 0: ready always high; 1: ready low 3 cycles on the second word; 2: random ready.
    // noisy: keep start asserted with random base/count while the burst runs.
    task automatic run_burst(input int b, input int c, input int mode, input bit noisy);
        int         k;
        int         stall_ctr;
        bit         hold;
        logic [7:0] held_d;
        logic [3:0] held_a;
        got_q.delete();
        first_v    = -1;
        done_cyc   = -1;
        last_x     = -1;
        gaps       = 0;
        got_sum    = 8'hxx;
        stall_seen = 0;
        k          = 0;
        stall_ctr  = 0;
        hold       = 1'b0;
        held_d     = 8'h00;
        held_a     = 4'h0;
        base       = b[3:0];
        count      = c[4:0];
        start      = 1'b1;
        abort      = 1'b0;
        out_ready  = 1'b1;
        while (k < 120 && done_cyc < 0) begin
            @(negedge clk);
            k++;
            if (k == 1 && eff_len(c) > 0) chk("rf_addr first issue", rf_addr, b[3:0]);
            if (hold) begin
                chk("stall valid held", out_valid, 1);
                chk("stall data held", out_data, held_d);
                chk("stall addr held", rf_addr, held_a);
            end
            if (out_valid && first_v < 0) first_v = k;
            if (done) begin
                done_cyc = k;
                got_sum  = checksum;
            end
            start = noisy && !done;
            if (noisy) begin
                base  = 4'($urandom);
                count = 5'($urandom);
            end
            case (mode)
                1: begin
                    out_ready = !(out_valid && got_q.size() == 1 && stall_ctr < 3);
                    if (!out_ready) stall_ctr++;
                    stall_seen = stall_ctr;
                end
                2: out_ready = ($urandom % 3) != 0;
                default: out_ready = 1'b1;
            endcase
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (last_x >= 0 && k - last_x != 1) gaps++;
                last_x = k;
            end
            hold   = out_valid && !out_ready;
            held_d = out_data;
            held_a = rf_addr;
        end
        chk("done seen", done_cyc >= 0, 1);
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("done single cycle", done, 0);
        chk("idle after done", busy, 0);
    endtask

    task automatic check_burst(input string tag, input int b, input int c, input int mode);
        int n;
        n = eff_len(c);
        chk({tag, " word count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk($sformatf("%s word%0d", tag, i), got_q[i], model_word(b, i));
        chk({tag, " checksum"}, got_sum, model_sum(b, c));
        chk({tag, " first valid cycle"}, first_v, (n > 0) ? 2 : -1);
        if (n == 0) chk({tag, " done latency"}, done_cyc, 1);
        else        chk({tag, " done after last"}, done_cyc - last_x, 1);
        if (mode == 0) chk({tag, " throughput gaps"}, gaps, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = 8'h10 + 8'(i);
        rst_n     = 1'b0;
        start     = 1'b0;
        base      = 4'h0;
        count     = 5'h0;
        abort     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset out_data", out_data, 0);
        chk("reset checksum", checksum, 0);
        chk("reset rf_addr", rf_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed bursts; 1E+1F+10+11 = 0x5E.
        vecs[0] = '{2,  4,  0, 8'h4E, 4};
        vecs[1] = '{14, 4,  0, 8'h5E, 4};
        vecs[2] = '{0,  0,  0, 8'h00, 0};
        vecs[3] = '{0,  20, 0, 8'h78, 16};
        vecs[4] = '{0,  3,  1, 8'h33, 3};
        for (int v = 0; v < 5; v++) begin
            run_burst(vecs[v].b, vecs[v].c, vecs[v].mode, 1'b0);
            check_burst($sformatf("vec%0d", v), vecs[v].b, vecs[v].c, vecs[v].mode);
            chk($sformatf("vec%0d table count", v), got_q.size(), vecs[v].exp_n);
            chk($sformatf("vec%0d table sum", v), got_sum, vecs[v].exp_sum);
            if (vecs[v].mode == 1) chk("stall cycles", stall_seen, 3);
        end

        // Abort after two of five transfers, with a simultaneous transfer.
        base = 4'd0; count = 5'd5; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort pre valid", out_valid, 1);
        chk("abort pre data", out_data, rf_mem[2]);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort out_valid", out_valid, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no done after abort", done, 0);
        end
        run_burst(5, 3, 0, 1'b0);
        check_burst("post-abort", 5, 3, 0);

        // Reset mid-burst with start held during reset.
        base = 4'd3; count = 5'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset busy", busy, 1);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("mid reset out_valid", out_valid, 0);
        chk("mid reset busy", busy, 0);
        chk("mid reset done", done, 0);
        chk("mid reset out_data", out_data, 0);
        chk("mid reset checksum", checksum, 0);
        chk("mid reset rf_addr", rf_addr, 0);
        @(negedge clk);
        chk("start during reset", busy, 0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("post reset busy", busy, 0);
        chk("post reset out_valid", out_valid, 0);
        run_burst(9, 6, 0, 1'b0);
        check_burst("post-reset", 9, 6, 0);

        // Randomized file contents, bursts and backpressure.
        for (int i = 0; i < 16; i++) rf_mem[i] = 8'($urandom);
        for (int t = 0; t < 40; t++) begin
            int rb;
            int rc;
            bit nz;
            rb = $urandom_range(0, 15);
            rc = $urandom_range(0, 31);
            nz = 1'($urandom);
            run_burst(rb, rc, 2, nz);
            check_burst($sformatf("rand%0d", t), rb, rc, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
